// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: AXI-Stream word in, framed serial out with selectable
// width, bit order, parity and stop-bit count; run-time baud divider, zero-gap back-to-back frames.
module uart_tx_cfg #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BIG_ENDIAN = 0,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  busy,
    output logic                  frame_done,
    input  logic [15:0]           prescale
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_t                state_q, state_d;
    logic [18:0]           cnt_q, cnt_d;
    logic [18:0]           bp_q, bp_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  parity_q, parity_d;
    logic [3:0]            bit_idx_q, bit_idx_d;
    logic                  stop_idx_q, stop_idx_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
    logic                  tready_q, tready_d;
    logic                  done_q, done_d;

    logic        accept;
    logic        cnt_zero;
    logic        last_stop;
    logic [18:0] bp_new;

    always_comb begin
        accept    = s_axis_tvalid && tready_q;
        cnt_zero  = (cnt_q == '0);
        last_stop = (state_q == S_STOP) && (stop_idx_q == LAST_STOP);
        bp_new    = (prescale == '0) ? 19'd8 : {prescale, 3'b000};

        state_d    = state_q;
        cnt_d      = cnt_zero ? '0 : cnt_q - 19'd1;
        bp_d       = bp_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        txd_d      = txd_q;
        tready_d   = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                txd_d    = 1'b1;
                tready_d = 1'b1;
            end
            S_START: begin
                if (cnt_zero) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                    cnt_d     = bp_q - 19'd1;
                    txd_d     = (BIG_ENDIAN != 0) ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
                    shreg_d   = (BIG_ENDIAN != 0) ? shreg_q << 1 : shreg_q >> 1;
                end
            end
            S_DATA: begin
                if (cnt_zero) begin
                    cnt_d = bp_q - 19'd1;
                    if (bit_idx_q == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            txd_d   = parity_q;
                        end else begin
                            state_d    = S_STOP;
                            stop_idx_d = 1'b0;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        txd_d     = (BIG_ENDIAN != 0) ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
                        shreg_d   = (BIG_ENDIAN != 0) ? shreg_q << 1 : shreg_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_zero) begin
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                    cnt_d      = bp_q - 19'd1;
                    txd_d      = 1'b1;
                end
            end
            S_STOP: begin
                // tready/frame_done are registered, so raise them one cycle ahead of the final stop cycle
                if (last_stop && cnt_q == 19'd1) begin
                    tready_d = 1'b1;
                    done_d   = 1'b1;
                end
                if (cnt_zero) begin
                    if (!last_stop) begin
                        stop_idx_d = stop_idx_q + 1'b1;
                        cnt_d      = bp_q - 19'd1;
                    end else begin
                        state_d  = S_IDLE;
                        tready_d = 1'b1;
                        txd_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        if (accept) begin
            state_d  = S_START;
            txd_d    = 1'b0;
            tready_d = 1'b0;
            bp_d     = bp_new;
            cnt_d    = bp_new - 19'd1;
            shreg_d  = s_axis_tdata;
            parity_d = (PARITY_ODD != 0) ? ~^s_axis_tdata : ^s_axis_tdata;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bp_q       <= '0;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            tready_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bp_q       <= bp_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            tready_q   <= tready_d;
            done_q     <= done_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign txd           = txd_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;

endmodule
